// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit words and writes them to
// consecutive instruction-memory addresses. Optional NOP padding on seal: ENC_NOP_PAD_EN.
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              seal,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              sealed
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
`ifdef ENC_NOP_PAD_EN
  localparam logic [31:0]       NOP_C   = 32'h0000_0013;
`endif

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_PAD    = 2'd1,
    ST_SEALED = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [31:0]       wr_data_r, wr_data_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic              err_r, err_s;
  logic              full_s, ready_s, xfer_s, legal_s;

  // Opcode is implied by the class; shift-immediates reuse the R-type funct7 slot.
  function automatic logic [31:0] encode(input logic [2:0] cls, input logic [2:0] f3,
                                         input logic f7, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [12:0] imm);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (cls)
      3'd0: w = {1'b0, f7, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      3'd1: w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'd2: w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd3: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      3'd4: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          w = {1'b0, f7, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else begin
          w = {imm[11:0], rs1, f3, rd, 7'b0010011};
        end
      end
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // count already includes the word sitting in the output register.
  assign full_s  = (count_r == DEPTH_C);
  assign ready_s = (state_r == ST_LOAD) && !full_s;
  assign xfer_s  = in_valid && ready_s;
  assign legal_s = (in_class <= 3'd4);

  // Next-state and next-output computation.
  always_comb begin
    state_s   = state_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    count_s   = count_r;
    err_s     = err_r;
    case (state_r)
      ST_LOAD: begin
        if (xfer_s && legal_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = BASE_C + count_r[ADDR_W-1:0];
          wr_data_s = encode(in_class, in_funct3, in_funct7_5, in_rd, in_rs1, in_rs2, in_imm);
          count_s   = count_r + ONE_C;
        end else if (xfer_s) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (seal) begin
`ifdef ENC_NOP_PAD_EN
          if (count_s == DEPTH_C) begin
            state_s = ST_SEALED;
          end else begin
            state_s = ST_PAD;
          end
`else
          state_s = ST_SEALED;
`endif
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_PAD: begin
`ifdef ENC_NOP_PAD_EN
        if (count_r != DEPTH_C) begin
          wr_en_s   = 1'b1;
          wr_addr_s = BASE_C + count_r[ADDR_W-1:0];
          wr_data_s = NOP_C;
          count_s   = count_r + ONE_C;
        end else begin
          count_s = count_r;
        end
        if (count_s == DEPTH_C) begin
          state_s = ST_SEALED;
        end else begin
          state_s = ST_PAD;
        end
`else
        state_s = ST_SEALED;
`endif
      end
      ST_SEALED: state_s = ST_SEALED;
      default:   state_s = ST_LOAD;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_LOAD;
      wr_en_r   <= 1'b0;
      wr_addr_r <= BASE_C;
      wr_data_r <= 32'h0000_0000;
      count_r   <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
      count_r   <= count_s;
      err_r     <= err_s;
    end
  end

  assign in_ready = ready_s;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign count    = count_r;
  assign full     = full_s;
  assign err      = err_r;
  assign sealed   = (state_r == ST_SEALED);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, hand-written corner sequences
// and a randomized run against an arithmetic reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_funct7_5, seal;
  logic [2:0]  in_class, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;

  logic        a_ready, a_wr_en, a_full, a_err, a_sealed;
  logic [5:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [6:0]  a_count;

  logic        b_ready, b_wr_en, b_full, b_err, b_sealed;
  logic [5:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [6:0]  b_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(6), .DEPTH(64), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .seal(seal),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .count(a_count),
    .full(a_full), .err(a_err), .sealed(a_sealed)
  );

  instr_encoder #(.ADDR_W(6), .DEPTH(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .seal(seal),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .count(b_count),
    .full(b_full), .err(b_err), .sealed(b_sealed)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [12:0] imm);
    in_valid = 1'b1; in_class = c; in_funct3 = f3; in_funct7_5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; seal = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Reference encoder built from field bit positions with plain arithmetic.
  function automatic logic [31:0] model_enc(input int unsigned cls, input int unsigned f3,
                                            input int unsigned f7, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input int unsigned imm);
    int unsigned op, w;
    case (cls)
      0: op = 51;
      1: op = 3;
      2: op = 35;
      3: op = 99;
      default: op = 19;
    endcase
    w = op + f3 * 32'd4096 + rs1 * 32'd32768;
    if (cls == 0)
      w += rd * 32'd128 + rs2 * 32'd1048576 + f7 * 32'h4000_0000;
    else if (cls == 2)
      w += (imm % 32) * 32'd128 + rs2 * 32'd1048576 + ((imm / 32) % 128) * 32'h0200_0000;
    else if (cls == 3)
      w += ((imm / 2) % 16) * 32'd256 + ((imm / 2048) % 2) * 32'd128 + rs2 * 32'd1048576
         + ((imm / 32) % 64) * 32'h0200_0000 + ((imm / 4096) % 2) * 32'h8000_0000;
    else if (cls == 4 && (f3 == 1 || f3 == 5))
      w += rd * 32'd128 + (imm % 32) * 32'd1048576 + f7 * 32'h4000_0000;
    else
      w += rd * 32'd128 + (imm % 4096) * 32'd1048576;
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nw;
    int unsigned m_count, m_err, m_wen, m_addr, m_data;
    logic [2:0]  rc, rf3;
    logic        rf7, rv;
    logic [4:0]  rrd, rrs1, rrs2;
    logic [12:0] rimm;

    vecs[0] = '{3'd0, 3'd0, 1'b0, 5'd3,  5'd1,  5'd2,  13'd0,    32'h0020_81B3};
    vecs[1] = '{3'd1, 3'd2, 1'b0, 5'd5,  5'd2,  5'd0,  13'd8,    32'h0081_2283};
    vecs[2] = '{3'd2, 3'd2, 1'b0, 5'd0,  5'd2,  5'd5,  13'd12,   32'h0051_2623};
    vecs[3] = '{3'd3, 3'd0, 1'b0, 5'd0,  5'd1,  5'd2,  13'h1FF8, 32'hFE20_8CE3};
    vecs[4] = '{3'd4, 3'd5, 1'b1, 5'd4,  5'd4,  5'd0,  13'd3,    32'h4032_5213};
    vecs[5] = '{3'd4, 3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  13'h0FFF, 32'hFFF0_0093};
    vecs[6] = '{3'd0, 3'd0, 1'b1, 5'd10, 5'd11, 5'd12, 13'd0,    32'h40C5_8533};
    vecs[7] = '{3'd1, 3'd2, 1'b1, 5'd5,  5'd2,  5'd31, 13'd8,    32'h0081_2283};
    vecs[8] = '{3'd4, 3'd1, 1'b0, 5'd1,  5'd1,  5'd0,  13'h0FE5, 32'h0050_9093};

    in_class = 3'd0; in_funct3 = 3'd0; in_funct7_5 = 1'b0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 13'd0;
    reset = 1'b1; in_valid = 1'b1; seal = 1'b0;
    step(); step();
    reset = 1'b0; in_valid = 1'b0;

    // reset state
    chk("rst_wr_en", a_wr_en, 0);
    chk("rst_wr_addr", a_wr_addr, 0);
    chk("rst_wr_data", a_wr_data, 0);
    chk("rst_count", a_count, 0);
    chk("rst_err", a_err, 0);
    chk("rst_sealed", a_sealed, 0);
    chk("rst_full", a_full, 0);
    chk("rst_ready", a_ready, 1);

    // table: back-to-back transfers
    for (int i = 0; i < 9; i++) begin
      chk("tbl_ready", a_ready, 1);
      drive(vecs[i].cls, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      step();
      chk("tbl_wr_en", a_wr_en, 1);
      chk("tbl_wr_addr", a_wr_addr, i);
      chk("tbl_wr_data", a_wr_data, vecs[i].exp);
      chk("tbl_count", a_count, i + 1);
    end
    in_valid = 1'b0;
    step();
    chk("tbl_idle_wr_en", a_wr_en, 0);
    chk("tbl_idle_count", a_count, 9);

    // illegal class between two adds
    do_reset();
    drive(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    step();
    chk("ill_w0_en", a_wr_en, 1);
    chk("ill_w0_addr", a_wr_addr, 0);
    drive(3'd6, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    chk("ill_ready", a_ready, 1);
    step();
    chk("ill_no_write", a_wr_en, 0);
    chk("ill_err", a_err, 1);
    chk("ill_count_hold", a_count, 1);
    drive(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    step();
    chk("ill_w1_en", a_wr_en, 1);
    chk("ill_w1_addr", a_wr_addr, 1);
    in_valid = 1'b0;
    step();
    chk("ill_count", a_count, 2);
    chk("ill_err_sticky", a_err, 1);

    // DEPTH=4 fill with valid held for 6 cycles
    do_reset();
    drive(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (b_wr_en) begin
        chk("full_addr", b_wr_addr, nw);
        nw++;
      end
    end
    chk("full_writes", nw, 4);
    chk("full_flag", b_full, 1);
    chk("full_ready", b_ready, 0);
    chk("full_count", b_count, 4);
    in_valid = 1'b0;

    // seal together with a transfer at count=1 (DEPTH=4)
    do_reset();
    drive(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    step();
    drive(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'h0FFF);
    seal = 1'b1;
    step();
    seal = 1'b0;
    chk("seal_w_en", b_wr_en, 1);
    chk("seal_w_addr", b_wr_addr, 1);
    chk("seal_w_data", b_wr_data, 32'hFFF0_0093);
    chk("seal_ready", b_ready, 0);
`ifdef ENC_NOP_PAD_EN
    chk("pad_not_sealed", b_sealed, 0);
    step();
    chk("pad0_en", b_wr_en, 1);
    chk("pad0_addr", b_wr_addr, 2);
    chk("pad0_data", b_wr_data, 32'h0000_0013);
    step();
    chk("pad1_en", b_wr_en, 1);
    chk("pad1_addr", b_wr_addr, 3);
    chk("pad1_data", b_wr_data, 32'h0000_0013);
    chk("pad_count", b_count, 4);
    step();
    chk("pad_done_en", b_wr_en, 0);
    chk("pad_sealed", b_sealed, 1);
`else
    chk("seal_sealed", b_sealed, 1);
    seal = 1'b1;
    step();
    chk("seal_hold_en", b_wr_en, 0);
    chk("seal_hold_count", b_count, 2);
    chk("seal_hold_addr", b_wr_addr, 1);
    chk("seal_hold_sealed", b_sealed, 1);
    seal = 1'b0;
`endif
    in_valid = 1'b0;

    // reset during PAD (or SEALED without padding) after one extra cycle
    do_reset();
    drive(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    step();
    seal = 1'b1;
    step();
    seal = 1'b0; in_valid = 1'b0;
    step();
`ifdef ENC_NOP_PAD_EN
    chk("rpad_nop", b_wr_data, 32'h0000_0013);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rpad_count", b_count, 0);
    chk("rpad_wr_en", b_wr_en, 0);
    chk("rpad_ready", b_ready, 1);
    chk("rpad_sealed", b_sealed, 0);
    chk("rpad_wr_addr", b_wr_addr, 0);

    // randomized run against the reference model (DEPTH=64)
    do_reset();
    m_count = 0; m_err = 0; m_wen = 0; m_addr = 0; m_data = 0;
    for (int cyc = 0; cyc < 160; cyc++) begin
      chk("rnd_wr_en", a_wr_en, m_wen);
      if (m_wen != 0) begin
        chk("rnd_wr_addr", a_wr_addr, m_addr);
        chk("rnd_wr_data", a_wr_data, m_data);
      end
      chk("rnd_count", a_count, m_count);
      chk("rnd_err", a_err, m_err);
      chk("rnd_ready", a_ready, (m_count < 64) ? 1 : 0);
      chk("rnd_full", a_full, (m_count == 64) ? 1 : 0);
      rv   = ($urandom % 4) != 0;
      rc   = (($urandom % 12) == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
      rf3  = 3'($urandom_range(0, 7));
      rf7  = 1'($urandom % 2);
      rrd  = 5'($urandom_range(0, 31));
      rrs1 = 5'($urandom_range(0, 31));
      rrs2 = 5'($urandom_range(0, 31));
      rimm = 13'($urandom_range(0, 8191));
      drive(rc, rf3, rf7, rrd, rrs1, rrs2, rimm);
      in_valid = rv;
      m_wen = 0;
      if (rv && m_count < 64) begin
        if (rc < 5) begin
          m_wen = 1;
          m_addr = m_count;
          m_data = model_enc(rc, rf3, rf7, rrd, rrs1, rrs2, rimm);
          m_count++;
        end else begin
          m_err = 1;
        end
      end
      step();
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the opcode decoder: takes decoded instruction intent (class, register indices, funct bits, immediate) over a valid/ready handshake.
- Assembles the RV32I 32-bit instruction word and writes it into instruction memory at sequential word addresses.
- Used by testbenches and boot logic to build programs for the single-cycle/forwarding core without hand-assembled hex.

Parameters:
- ADDR_W, 6: instruction-memory word-address width.
- DEPTH, 64: maximum words per session (DEPTH <= 2^ADDR_W).
- BASE_ADDR, 0: word address of the first write.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder can accept this cycle
- in_class  input  3  0=R(0110011), 1=LOAD(0000011), 2=STORE(0100011), 3=BRANCH(1100011), 4=ALU-IMM(0010011), 5-7 illegal
- in_funct3  input  3  funct3
- in_funct7_5  input  1  instruction bit 30 (R sub/sra, ALU-IMM srai)
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  13  signed immediate; [11:0] for LOAD/STORE/ALU-IMM; [12:1] byte offset for BRANCH, bit0 ignored
- seal  input  1  end of program; no further input accepted
- wr_en  output  1  instruction-memory write strobe
- wr_addr  output  ADDR_W  write word address
- wr_data  output  32  encoded instruction
- count  output  ADDR_W+1  words written this session
- full  output  1  count == DEPTH
- err  output  1  sticky: illegal class seen
- sealed  output  1  in SEALED state

Behaviour:
- Reset values (synchronous, dominates all other inputs):
  - wr_en=0, wr_addr=BASE_ADDR, wr_data=0, count=0, err=0, sealed=0, state=LOAD.
  - A reset asserted mid-operation, including in PAD, aborts immediately with the same values.
- States:
  - LOAD: accepting instructions.
  - PAD: present only with the optional feature.
  - SEALED: terminal until reset.
- Handshake and ready:
  - Transfer occurs when in_valid & in_ready.
  - in_ready = (state==LOAD) & ~full_next, where full_next counts a write pending in the output register.
  - in_ready has no combinational dependence on in_valid.
  - Throughput is one instruction per cycle.
- Latency: the accepted word is registered and appears on wr_data with wr_en=1 exactly one cycle after the transfer.
  - wr_addr = BASE_ADDR + count, using the pre-increment count value.
  - count increments on the cycle wr_en is high.
- Encoding (opcode fixed by class):
  - R: {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, op}.
  - LOAD / ALU-IMM (non-shift): {imm[11:0], rs1, funct3, rd, op}.
  - ALU-IMM with funct3 = 001 or 101: {1'b0, funct7_5, 5'b0, imm[4:0], rs1, funct3, rd, op}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - Fields unused by a format are ignored.
- Illegal class (5-7): the transfer completes, no write is issued, count is unchanged, and err is set (cleared only by reset).
- Full: when count reaches DEPTH, in_ready=0.
  - A transfer offered while full is not accepted; fields are held by the source.
  - Addresses never wrap.
- Seal:
  - seal sampled high in LOAD moves to SEALED (or PAD).
  - If a transfer happens in the same cycle as seal, that instruction is still written.
  - seal is ignored outside LOAD.
- SEALED: in_ready=0, wr_en=0, sealed=1, outputs hold.

Optional Feature:
- ENC_NOP_PAD_EN defined:
  - seal moves to PAD after any pending write.
  - PAD writes NOP 0x00000013 at consecutive addresses, one per cycle, until count==DEPTH, then enters SEALED.
  - If already full at seal, PAD lasts zero cycles.
- Undefined: no PAD state; seal goes straight to SEALED and unused memory is untouched.

Test Plan:
- Reset, then R add rd=3,rs1=1,rs2=2,f3=0,f7_5=0 -> next cycle wr_en=1, wr_addr=0, wr_data=0x002081B3, count=1.
- Back-to-back over 4 cycles:
  - LOAD rd=5,rs1=2,imm=8,f3=010 -> 0x00812283 @1.
  - STORE rs2=5,rs1=2,imm=12,f3=010 -> 0x00512623 @2.
  - BRANCH rs1=1,rs2=2,imm=-8(0x1FF8),f3=0 -> 0xFE208CE3 @3.
  - ALU-IMM srai rd=4,rs1=4,f3=101,f7_5=1,imm=3 -> 0x40325213 @4.
  - All four with in_ready held at 1.
- in_class=6 sent between two valid adds -> err=1, only 2 writes at consecutive addresses, count=2.
- DEPTH=4, in_valid held high for 6 cycles -> exactly 4 writes (addr 0-3), full=1, in_ready=0 afterward.
- seal in the same cycle as a transfer at count=1 -> that word written @1, then sealed=1, in_ready=0.
  - With ENC_NOP_PAD_EN and DEPTH=4: 0x00000013 written @2 and @3, then sealed=1.
- Reset asserted during PAD after one NOP -> next cycle count=0, wr_en=0, state LOAD, in_ready=1.
